// File: rtl/rosetta_pkg.sv
// Shared constants and types for the ROSETTA normalizer datapath.
package rosetta_pkg;

   // Default widths for the normalizer and its leading-zero counter.
   localparam int unsigned DefLzcWidth = 7;
   localparam int unsigned DefIWidth   = 2 ** (DefLzcWidth - 1);
   localparam int unsigned DefExpWidth = 10;

   // Most negative two's-complement exponent representable in w bits.
   function automatic int min_exp(input int unsigned w);
      return -(2 ** (w - 1));
   endfunction

   localparam int DefMinExp = min_exp(DefExpWidth);

   // Normalized result as seen at the default widths.
   typedef struct packed {
      logic [DefIWidth-1:0]   mant;
      logic [DefExpWidth-1:0] exp;
      logic                   sign;
      logic                   zero;
      logic                   underflow;
   } norm_res_t;

endpackage

// File: rtl/norm_shift_pipe_lzcu.sv
// Recursive leading-zero counter: count of zeros above the first set bit,
// equal to the full width when the input is all zero.
module lzcu #(
   parameter int unsigned LZC_WIDTH = 7
) (
   input  logic [2**(LZC_WIDTH-1)-1:0] bits,
   output logic [LZC_WIDTH-1:0]        count
);

   if (LZC_WIDTH == 1) begin : g_leaf
      assign count = ~bits;
   end else begin : g_node
      localparam int unsigned Half = 2 ** (LZC_WIDTH - 2);

      logic [LZC_WIDTH-2:0] hi_cnt;
      logic [LZC_WIDTH-2:0] lo_cnt;

      lzcu #(
         .LZC_WIDTH(LZC_WIDTH - 1)
      ) u_hi (
         .bits (bits[2*Half-1:Half]),
         .count(hi_cnt)
      );

      lzcu #(
         .LZC_WIDTH(LZC_WIDTH - 1)
      ) u_lo (
         .bits (bits[Half-1:0]),
         .count(lo_cnt)
      );

      // MSB of a half count is set only when that half is entirely zero.
      assign count = hi_cnt[LZC_WIDTH-2] ? ({1'b0, lo_cnt} + LZC_WIDTH'(Half))
                                         : {1'b0, hi_cnt};
   end

endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage normalizer: S1 registers the operand with its leading-zero count,
// S2 shifts, adjusts and saturates the exponent. Full valid/ready backpressure.
module norm_shift_pipe
   import rosetta_pkg::*;
#(
   parameter int unsigned LZC_WIDTH = DefLzcWidth,
   parameter int unsigned I_WIDTH   = 2 ** (LZC_WIDTH - 1),
   parameter int unsigned EXP_WIDTH = DefExpWidth
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [I_WIDTH-1:0]   in_mant,
   input  logic [EXP_WIDTH-1:0] in_exp,
   input  logic                 in_sign,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [I_WIDTH-1:0]   out_mant,
   output logic [EXP_WIDTH-1:0] out_exp,
   output logic                 out_sign,
   output logic                 out_zero,
   output logic                 out_underflow
);

   localparam logic [EXP_WIDTH:0]   MinExpExt = (EXP_WIDTH + 1)'(min_exp(EXP_WIDTH));
   localparam logic [EXP_WIDTH-1:0] MinExp    = MinExpExt[EXP_WIDTH-1:0];

   logic                 s1_v;
   logic [I_WIDTH-1:0]   s1_mant;
   logic [EXP_WIDTH-1:0] s1_exp;
   logic                 s1_sign;
   logic [LZC_WIDTH-1:0] s1_lz;
   logic [LZC_WIDTH-1:0] lz_in;

   logic                 s2_v;
   logic                 in_fire;
   logic                 s2_adv;

   logic [I_WIDTH-1:0]   res_mant;
   logic [EXP_WIDTH-1:0] res_exp;
   logic                 res_zero;
   logic                 res_uf;
   logic [EXP_WIDTH:0]   e_ext;

   lzcu #(
      .LZC_WIDTH(LZC_WIDTH)
   ) u_lzcu (
      .bits (in_mant),
      .count(lz_in)
   );

   assign s2_adv    = s1_v & (~s2_v | out_ready);
   assign in_ready  = ~rst & (~s1_v | ~s2_v | out_ready);
   assign in_fire   = in_valid & in_ready;
   assign out_valid = s2_v;

   // S1: capture operand and its zero count; empties when S2 takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s1_mant <= '0;
         s1_exp  <= '0;
         s1_sign <= 1'b0;
         s1_lz   <= '0;
      end else if (in_fire) begin
         s1_v    <= 1'b1;
         s1_mant <= in_mant;
         s1_exp  <= in_exp;
         s1_sign <= in_sign;
         s1_lz   <= lz_in;
      end else if (s2_adv) begin
         s1_v    <= 1'b0;
      end
   end

   // S2 datapath: barrel shift plus widened exponent subtract with saturation.
   always_comb begin
      res_mant = '0;
      res_exp  = '0;
      res_zero = 1'b0;
      res_uf   = 1'b0;
      e_ext    = {s1_exp[EXP_WIDTH-1], s1_exp} - (EXP_WIDTH + 1)'(s1_lz);
      if (s1_lz == LZC_WIDTH'(I_WIDTH)) begin
         res_zero = 1'b1;
      end else begin
         res_mant = s1_mant << s1_lz;
         if ($signed(e_ext) < $signed(MinExpExt)) begin
            res_exp = MinExp;
            res_uf  = 1'b1;
         end else begin
            res_exp = e_ext[EXP_WIDTH-1:0];
         end
      end
   end

   // S2 registers: load on advance, hold while stalled, clear valid on transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v          <= 1'b0;
         out_mant      <= '0;
         out_exp       <= '0;
         out_sign      <= 1'b0;
         out_zero      <= 1'b0;
         out_underflow <= 1'b0;
      end else if (s2_adv) begin
         s2_v          <= 1'b1;
         out_mant      <= res_mant;
         out_exp       <= res_exp;
         out_sign      <= s1_sign;
         out_zero      <= res_zero;
         out_underflow <= res_uf;
      end else if (out_ready) begin
         s2_v          <= 1'b0;
      end
   end

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Self-checking bench for norm_shift_pipe with a behavioural normalizer model.
module tb_norm_shift_pipe;
   import rosetta_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_mant;
   logic [9:0]  in_exp;
   logic        in_sign;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_mant;
   logic [9:0]  out_exp;
   logic        out_sign;
   logic        out_zero;
   logic        out_underflow;

   int n_checks = 0;
   int n_pass   = 0;
   int occ      = 0;
   norm_res_t exp_q[$];

   norm_shift_pipe #(
      .LZC_WIDTH(7),
      .I_WIDTH  (64),
      .EXP_WIDTH(10)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_mant      (in_mant),
      .in_exp       (in_exp),
      .in_sign      (in_sign),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_mant     (out_mant),
      .out_exp      (out_exp),
      .out_sign     (out_sign),
      .out_zero     (out_zero),
      .out_underflow(out_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: find the top set bit, shift it to bit 63, subtract with integers.
   function automatic norm_res_t ref_norm(input logic [63:0] m, input logic [9:0] ex,
                                          input logic s);
      norm_res_t r;
      int lz;
      int e;
      lz = 64;
      for (int i = 0; i < 64; i++) if (m[i]) lz = 63 - i;
      r.sign = s;
      if (lz == 64) begin
         r.mant = '0;
         r.exp = '0;
         r.zero = 1'b1;
         r.underflow = 1'b0;
      end else begin
         r.mant = m << lz;
         r.zero = 1'b0;
         e = int'($signed(ex)) - lz;
         if (e < -512) begin
            r.exp = 10'h200;
            r.underflow = 1'b1;
         end else begin
            r.exp = e[9:0];
            r.underflow = 1'b0;
         end
      end
      return r;
   endfunction

   function automatic logic [63:0] rand_mant();
      logic [63:0] m;
      int sh;
      m = {$urandom, $urandom};
      sh = $urandom_range(0, 64);
      return (sh == 64) ? 64'h0 : (m >> sh);
   endfunction

   function automatic logic [9:0] rand_exp();
      int v;
      if ($urandom_range(0, 1) == 0) return 10'($urandom);
      v = -int'($urandom_range(440, 512));
      return v[9:0];
   endfunction

   function automatic norm_res_t dut_res();
      norm_res_t g;
      g.mant = out_mant;
      g.exp = out_exp;
      g.sign = out_sign;
      g.zero = out_zero;
      g.underflow = out_underflow;
      return g;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_mant = '0;
      in_exp = '0;
      in_sign = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", in_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, dut_res()} !== '0)
         $display("FAIL reset_outputs got valid=%b res=%h want all zero", out_valid, dut_res());
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_release_ready got=%b want=1", in_ready);
      else n_pass++;
      occ = 0;
   endtask

   task automatic test_directed();
      logic [63:0] vm[4];
      logic [9:0]  ve[4];
      logic        vs[4];
      norm_res_t   vr[4];
      vm[0] = 64'h1;                   ve[0] = 10'd0;   vs[0] = 1'b1;
      vr[0] = '{mant: 64'h8000_0000_0000_0000, exp: 10'h3C1, sign: 1'b1, zero: 1'b0,
                underflow: 1'b0};
      vm[1] = 64'h8000_0000_0000_0001; ve[1] = 10'd5;   vs[1] = 1'b0;
      vr[1] = '{mant: 64'h8000_0000_0000_0001, exp: 10'd5, sign: 1'b0, zero: 1'b0,
                underflow: 1'b0};
      vm[2] = 64'h0;                   ve[2] = 10'd17;  vs[2] = 1'b1;
      vr[2] = '{mant: 64'h0, exp: 10'h0, sign: 1'b1, zero: 1'b1, underflow: 1'b0};
      vm[3] = 64'h1;                   ve[3] = 10'h20C; vs[3] = 1'b0;
      vr[3] = '{mant: 64'h8000_0000_0000_0000, exp: 10'h200, sign: 1'b0, zero: 1'b0,
                underflow: 1'b1};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_mant = vm[k];
         in_exp = ve[k];
         in_sign = vs[k];
         out_ready = 1'b1;
         #1;
         n_checks++;
         if (in_ready !== 1'b1) $display("FAIL dir%0d_in_ready got=%b want=1", k, in_ready);
         else n_pass++;
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         n_checks++;
         if (out_valid !== 1'b0) $display("FAIL dir%0d_early_valid got=%b want=0", k, out_valid);
         else n_pass++;
         @(posedge clk);
         #1;
         n_checks++;
         if (out_valid !== 1'b1) $display("FAIL dir%0d_latency got=%b want=1", k, out_valid);
         else n_pass++;
         n_checks++;
         if (dut_res() !== vr[k]) $display("FAIL dir%0d_result got=%h want=%h", k, dut_res(), vr[k]);
         else n_pass++;
      end
      @(negedge clk);
      @(negedge clk);
      occ = 0;
   endtask

   task automatic test_random(input int cycles, input int ready_pct);
      norm_res_t e;
      bit drain;
      int c;
      c = 0;
      while (c < cycles + 20) begin
         drain = (c >= cycles);
         if (drain && exp_q.size() == 0) break;
         @(negedge clk);
         in_valid = drain ? 1'b0 : ($urandom_range(0, 99) < 70);
         in_mant = rand_mant();
         in_exp = rand_exp();
         in_sign = 1'($urandom);
         out_ready = drain ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
         #1;
         n_checks++;
         if (in_ready !== ((occ < 2) || out_ready))
            $display("FAIL rand_in_ready got=%b want=%b occ=%0d", in_ready,
                     ((occ < 2) || out_ready), occ);
         else n_pass++;
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL rand_spurious_beat got=%h want=none", dut_res());
            end else begin
               e = exp_q.pop_front();
               if (dut_res() !== e) $display("FAIL rand_result got=%h want=%h", dut_res(), e);
               else n_pass++;
            end
            occ--;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_norm(in_mant, in_exp, in_sign));
            occ++;
         end
         c++;
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL rand_drain_timeout got=%0d left want=0", exp_q.size());
      else n_pass++;
      exp_q.delete();
      occ = 0;
   endtask

   task automatic test_backpressure();
      logic [63:0] bm[4];
      norm_res_t e;
      int sent;
      int got;
      int cyc;
      for (int k = 0; k < 4; k++) bm[k] = rand_mant() | 64'h1;
      sent = 0;
      got = 0;
      cyc = 0;
      while (got < 4 && cyc < 30) begin
         @(negedge clk);
         out_ready = (cyc >= 3);
         in_valid = (sent < 4);
         in_mant = bm[sent % 4];
         in_exp = 10'(sent * 3);
         in_sign = sent[0];
         #1;
         n_checks++;
         if (in_ready !== ((occ < 2) || out_ready))
            $display("FAIL bp_in_ready got=%b want=%b cyc=%0d", in_ready,
                     ((occ < 2) || out_ready), cyc);
         else n_pass++;
         if (cyc == 2) begin
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL bp_full_stall got=%b want=0", in_ready);
            else n_pass++;
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL bp_spurious_beat got=%h want=none", dut_res());
            end else begin
               e = exp_q.pop_front();
               if (dut_res() !== e) $display("FAIL bp_order got=%h want=%h", dut_res(), e);
               else n_pass++;
            end
            occ--;
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_norm(in_mant, in_exp, in_sign));
            occ++;
            sent++;
         end
         cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (got != 4 || out_valid !== 1'b0)
         $display("FAIL bp_count got=%0d beats valid=%b want=4 beats valid=0", got, out_valid);
      else n_pass++;
      exp_q.delete();
      occ = 0;
   endtask

   task automatic test_reset_midstream();
      int loaded;
      loaded = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 6 && loaded < 2; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_mant = rand_mant() | 64'h100;
         in_exp = rand_exp();
         in_sign = 1'b1;
         #1;
         if (in_ready) loaded++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL rst_mid_full got valid=%b ready=%b want valid=1 ready=0",
                  out_valid, in_ready);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready got=%b want=0", in_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, dut_res()} !== '0)
         $display("FAIL rst_mid_flush got valid=%b res=%h want all zero", out_valid, dut_res());
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL rst_mid_release got=%b want=1", in_ready);
      else n_pass++;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) $display("FAIL rst_mid_stale got=%b want=0 cyc=%0d", out_valid, c);
         else n_pass++;
      end
      exp_q.delete();
      occ = 0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random(400, 60);
      test_backpressure();
      test_reset_midstream();
      test_random(300, 90);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/norm_shift_pipe.md
# norm_shift_pipe

Two-stage pipelined normalizer placed directly downstream of the leading-zero counting unit in the ROSETTA datapath. It accepts an unnormalized magnitude with exponent and sign, counts leading zeros, left-shifts the magnitude so its MSB is 1, and decrements the exponent by the shift amount. Zero and exponent underflow are flagged. Valid/ready handshakes on both sides support full backpressure.

## Interface
- `LZC_WIDTH`, default 7: width of the zero count; the count ranges 0..I_WIDTH.
- `I_WIDTH`, default 2**(LZC_WIDTH-1) = 64: magnitude width; must be a power of two, at least 2.
- `EXP_WIDTH`, default 10: two's-complement exponent width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_mant` in I_WIDTH: unnormalized magnitude.
- `in_exp` in EXP_WIDTH: signed exponent.
- `in_sign` in 1: sign; passed through unchanged.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: consumer accepts the beat.
- `out_mant` out I_WIDTH: normalized magnitude; MSB is 1 unless `out_zero` is set.
- `out_exp` out EXP_WIDTH: adjusted signed exponent.
- `out_sign` out 1: sign.
- `out_zero` out 1: input magnitude was 0.
- `out_underflow` out 1: exponent saturated at its minimum.

## Operation
- A beat transfers when valid and ready are both high at a rising edge. The input side and output side use the same rule.
- Stage 1 (S1) registers `in_mant`, `in_exp`, `in_sign` and the leading-zero count `lz` (LZC_WIDTH bits) computed from `in_mant`. It also holds the flag `s1_v`.
- Stage 2 (S2) computes the result from the S1 registers and registers it into the output registers. It also holds the flag `s2_v`, which drives `out_valid`.
  - If `lz == I_WIDTH`: `out_mant=0`, `out_exp=0`, `out_zero=1`, `out_underflow=0`.
  - Otherwise: `out_mant = mant << lz` and `e = sext(exp) - lz`, computed at EXP_WIDTH+1 bits.
  - If `e < -2**(EXP_WIDTH-1)`: `out_exp = -2**(EXP_WIDTH-1)` and `out_underflow=1`. Otherwise `out_exp = e[EXP_WIDTH-1:0]` and `out_underflow=0`.
  - `out_zero=0` in the non-zero case.
- Stage advance rules:
  - `s2_adv = s1_v & (~s2_v | out_ready)`.
  - `in_ready = ~rst & (~s1_v | ~s2_v | out_ready)`.
- S2 holds its data stable while `out_valid & ~out_ready`.
- S1 holds its data stable while it is valid and S2 cannot advance.
- A simultaneous accept into S1 and advance out of S1 in the same cycle is legal and loses no data.
- Beats leave in the same order they entered. There is no reordering and no drop except on reset.
- Reset sets `s1_v`, `s2_v` and all data and flag registers to 0. Any beats in flight when `rst` is asserted are discarded.
- Reset values of outputs: `out_valid=0`, `out_mant=0`, `out_exp=0`, `out_sign=0`, `out_zero=0`, `out_underflow=0`. `in_ready=0` while `rst` is high.

## Timing
- Latency is 2 cycles: a beat accepted at edge N is presented with `out_valid` high after edge N+1, and can transfer at edge N+2 at the earliest.
- Throughput is 1 beat per cycle while `out_ready` stays high.
- `in_ready` is combinational from `out_ready` and the stage valid flags. There is no combinational path from `in_valid` or `in_mant` to any output.
- The critical path is the barrel shift plus the exponent subtract in S2. The leading-zero count is computed in the S1 input cone.
- `in_ready` rises the cycle after `rst` is deasserted.

## Structure
- The shared package `rosetta_pkg` holds:
  - the default `LZC_WIDTH`, `I_WIDTH` and `EXP_WIDTH` values;
  - the minimum-exponent constant expression;
  - a packed normalized-result type containing mant, exp, sign, zero and underflow.
- One sub-module: the recursive leading-zero counter `LZCU`, instantiated with `LZC_WIDTH`, driving the S1 `lz` register.
- Shift, subtract, saturate and the handshake logic stay in this module.

## Test plan
- Normalize: `in_mant=64'h1`, `in_exp=0`, `in_sign=1` -> 2 cycles later `out_mant=64'h8000_0000_0000_0000`, `out_exp=-63` (10'h3C1), `out_sign=1`, both flags 0.
- Already normalized: `in_mant=64'h8000_0000_0000_0001`, `in_exp=5` -> `out_mant` unchanged, `out_exp=5`.
- Zero: `in_mant=0`, `in_exp=17` -> `out_zero=1`, `out_mant=0`, `out_exp=0`.
- Underflow: `in_mant=64'h1`, `in_exp=-500` -> `out_exp=-512` (10'h200), `out_underflow=1`, `out_mant=64'h8000_0000_0000_0000`.
- Backpressure: 4 back-to-back beats with `out_ready` low for 3 cycles -> `in_ready` drops after 2 beats are held, and all 4 beats emerge in order with no duplicates.
- Reset mid-stream: `rst` pulsed while both stages are valid -> `out_valid=0` on the next cycle, no stale beat is emitted, and `in_ready=1` one cycle after release.
